// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default parameters,
// FSM states and the encodings for the initial register contents.
package regfile_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NREGS_DEF    = 32;
  localparam int NRD_DEF      = 2;
  localparam int ZERO_REG_DEF = 1;

  localparam int INIT_ZERO  = 0;
  localparam int INIT_INDEX = 1;
  localparam int INIT_MODE_DEF = INIT_INDEX;

  // state | meaning
  // INIT  | sweeping the array with initial values, one register per cycle
  // RUN   | normal operation, writes and reservations accepted
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on reservation, cleared on write-back.
// A reservation and a write-back to the same register leave it busy.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = NRD_DEF,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hold,
  input  logic                    set_en,
  input  logic [AW-1:0]           set_addr,
  input  logic                    clr_en,
  input  logic [AW-1:0]           clr_addr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0]          rd_busy
);

  logic [NREGS-1:0] busy;

  always_ff @(posedge clk) begin
    if (rst || hold) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (set_en && set_addr == AW'(i))
          busy[i] <= 1'b1;
        else if (clr_en && clr_addr == AW'(i))
          busy[i] <= 1'b0;
      end
    end
  end

  // A write-back in flight hides the busy bit; a same-cycle reservation does not show yet.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NRD; k++)
      rd_busy[k] = busy[rd_addr[k]] & ~(clr_en && clr_addr == rd_addr[k]);
  end

endmodule

// File: rtl/regfile_sb.sv
// Flop-based multi-port register file with write bypass, busy scoreboard
// and a self-initialising sweep after reset.
module regfile_sb import regfile_pkg::*; #(
  parameter  int XLEN      = XLEN_DEF,
  parameter  int NREGS     = NREGS_DEF,
  parameter  int NRD       = NRD_DEF,
  parameter  int ZERO_REG  = ZERO_REG_DEF,
  parameter  int INIT_MODE = INIT_MODE_DEF,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [NRD-1:0][AW-1:0]   rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic                     we,
  input  logic [AW-1:0]            wa,
  input  logic [XLEN-1:0]          wd,
  input  logic                     rsv_valid,
  input  logic [AW-1:0]            rsv_addr,
  input  logic [AW-1:0]            probe_addr,
  output logic [XLEN-1:0]          probe_data
);

  localparam bit ZR = (ZERO_REG != 0);

  state_t            state, state_nxt;
  logic [AW-1:0]     cnt;
  logic              init_wr;
  logic [XLEN-1:0]   init_val;
  logic              wr_en, set_en, clr_en;
  logic [XLEN-1:0]   mem [NREGS];

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (cnt == AW'(NREGS - 1)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    ready   = 1'b0;
    init_wr = 1'b0;
    case (state)
      INIT:    init_wr = 1'b1;
      RUN:     ready   = 1'b1;
      default: ;
    endcase
  end

  // Counter wraps back to 0 on the last INIT write, so it rests at 0 in RUN.
  always_ff @(posedge clk) begin
    if (rst)          cnt <= '0;
    else if (init_wr) cnt <= cnt + AW'(1);
  end

  assign init_val = (INIT_MODE == INIT_INDEX) ? XLEN'(cnt) : '0;
  assign wr_en    = ready & we & ~(ZR && wa == '0);
  assign clr_en   = ready & we;
  assign set_en   = ready & rsv_valid & ~(ZR && rsv_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_wr)    mem[cnt] <= init_val;
      else if (wr_en) mem[wa]  <= wd;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ZR && rd_addr[k] == '0)
        rd_data[k] = '0;
      else if (ready && we && wa == rd_addr[k])
        rd_data[k] = wd;
      else
        rd_data[k] = mem[rd_addr[k]];
    end
  end

  assign probe_data = (ZR && probe_addr == '0) ? '0 : mem[probe_addr];

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .hold     (init_wr),
    .set_en   (set_en),
    .set_addr (rsv_addr),
    .clr_en   (clr_en),
    .clr_addr (wa),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, at least 4; AW = clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports, 1 to 4.
REQ-004 Parameter ZERO_REG, default 1: register 0 reads 0 and ignores writes and reservations.
REQ-005 Parameter INIT_MODE, default 1: 0 means initialise to zero, 1 means register i = i, zero-extended to XLEN.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 ready  out  1  high when the block is in RUN.
REQ-009 rd_addr  in  NRD x AW  read addresses.
REQ-010 rd_data  out  NRD x XLEN  read data.
REQ-011 rd_busy  out  NRD  pending-write flag per read port.
REQ-012 we / wa / wd  in  1 / AW / XLEN  write-back enable, address, data.
REQ-013 rsv_valid / rsv_addr  in  1 / AW  reserve a destination register (issue).
REQ-014 probe_addr / probe_data  in AW / out XLEN  debug read port; no bypass.

Function
REQ-015 FSM states: INIT and RUN; the reset state is INIT.
REQ-016 INIT: an AW-bit counter starts at 0 and writes the INIT_MODE value to one register per cycle.
REQ-017 INIT: ready stays 0; the block enters RUN the cycle after the counter writes NREGS-1; INIT lasts exactly NREGS cycles.
REQ-018 INIT: we and rsv_valid are ignored, and all busy bits are held at 0.
REQ-019 RUN: when we=1, array[wa] takes wd at the edge.
REQ-020 Write bypass: rd_data[k] = wd in the same cycle when we=1 and wa==rd_addr[k]; otherwise rd_data[k] = array[rd_addr[k]], combinationally.
REQ-021 ZERO_REG=1: reads of address 0 (read ports and probe) return 0; writes and reservations to address 0 are dropped.
REQ-022 Scoreboard: a per-register busy bit. rsv_valid sets busy[rsv_addr] at the edge; we clears busy[wa] at the edge.
REQ-023 Simultaneous rsv_valid and we to the same address: the reservation wins and busy stays 1. A reservation to an already-busy register keeps it at 1; there is no counting.
REQ-024 rd_busy[k] = busy[rd_addr[k]] AND NOT (we AND wa==rd_addr[k]); a reservation made in the same cycle is not visible until the next cycle.
REQ-025 Multiple read ports with equal addresses return identical data and busy values.
REQ-026 probe_data = array[probe_addr] (0 for address 0 when ZERO_REG=1); the probe never bypasses.
REQ-027 During INIT, rd_data and probe_data return array contents, which are undefined for registers not yet written; rd_busy = 0.

Reset
REQ-028 rst=1 at an edge: the FSM goes to INIT, the counter goes to 0, all busy bits go to 0, and ready goes to 0 in the next cycle.
REQ-029 rst asserted mid-INIT or in RUN restarts initialisation from register 0.
REQ-030 A write or reservation in the same cycle as rst is discarded.
REQ-031 Held rst keeps the block in INIT with the counter at 0; the NREGS-cycle count starts at the first edge with rst=0.

Structure
REQ-032 Package regfile_pkg holds default parameter values, the FSM state enum (INIT, RUN), and the INIT_MODE encodings.
REQ-033 Scoreboard logic is a separate sub-module, regfile_scoreboard (busy vector, set/clear priority, rd_busy generation), instantiated once.
REQ-034 The register array is flop-based with no memory macro, so asynchronous multi-port reads are supported.

Verification
REQ-035 Reset then init: rst held 1 cycle with defaults -> ready=0 for 32 cycles, then ready=1; probe_addr=5 -> probe_data=5; probe_addr=31 -> 31.
REQ-036 Bypass: RUN, we=1, wa=7, wd=0xDEADBEEF, rd_addr[0]=7 in the same cycle -> rd_data[0]=0xDEADBEEF that cycle; probe_data(7) shows 7 that cycle and 0xDEADBEEF the next.
REQ-037 Zero register: we=1, wa=0, wd=0x1234 plus rsv_valid=1, rsv_addr=0 -> rd_data for address 0 = 0 and rd_busy = 0 on all following cycles.
REQ-038 Scoreboard: rsv_addr=3 at cycle t -> rd_busy=1 for address 3 from t+1. Write wa=3 at t+4 -> rd_busy=0 during t+4 and after. Simultaneous rsv and write to 9 -> busy[9] stays 1.
REQ-039 Mid-operation reset: registers written to 0xFFFF_FFFF and busy bits set, then rst pulsed 1 cycle -> all busy=0, ready low for 32 cycles, and register 10 reads 10 afterwards.
REQ-040 Parameter sweep with NREGS=8, NRD=4, INIT_MODE=0, ZERO_REG=0 -> INIT lasts 8 cycles, all registers read 0, and a write to register 0 with 0xA5 is read back as 0xA5 on all 4 ports.
